// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared types and defaults for the round-robin mux arbiter.
//   N_REQ_DEF / DATA_W_DEF : default requester count and data width
//   src_t                  : source index at the default requester count
//   out_state_t            : occupancy of the single-entry output stage
package rr_mux_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int DATA_W_DEF = 4;
    localparam int SRC_W_DEF  = $clog2(N_REQ_DEF);

    typedef logic [SRC_W_DEF-1:0] src_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/rr_mux_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search.
// Ports:
//   req [N_REQ]  : request vector
//   ptr [SRC_W]  : highest-priority index; search runs ptr, ptr+1, ... mod N_REQ
//   win [SRC_W]  : first requesting index in search order (0 offset when none)
//   any          : at least one request is present
// N_REQ must be a power of two so that index arithmetic wraps for free.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int SRC_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SRC_W-1:0] ptr,
    output logic [SRC_W-1:0] win,
    output logic             any
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SRC_W-1:0]   off;

    always_comb begin
        // Rotate right by ptr so bit 0 of rot is requester ptr.
        dbl = {req, req} >> ptr;
        rot = dbl[N_REQ-1:0];
        off = '0;
        // Walk downwards so the lowest set bit is the one left standing.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = SRC_W'(i);
        end
        // Rotate the index back; power-of-two width wraps mod N_REQ.
        win = off + ptr;
        any = |req;
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: shares one data selector among N_REQ requesters using a
// round-robin pointer, registering the chosen word into a single-entry
// output stage.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid [N_REQ]   : requester i offers a word
//   req_data  [N_REQ*DATA_W] : requester i word at [i*DATA_W +: DATA_W]
//   req_lock  [N_REQ]   : (RR_MUX_ARB_LOCK_EN only) keep priority after transfer
//   req_ready [N_REQ]   : combinational one-hot (or zero) acceptance
//   out_valid/out_data/out_src/out_ready : registered output handshake
//   dbg_state, dbg_ptr  : output-stage state and priority pointer
// Handshake: a word moves whenever valid and ready are both high at a
// posedge; valid never depends on ready, ready may depend on valid.
// Optional feature macro: RR_MUX_ARB_LOCK_EN (adds req_lock burst hold).
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SRC_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
`ifdef RR_MUX_ARB_LOCK_EN
    input  logic [N_REQ-1:0]        req_lock,
`endif
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [SRC_W-1:0]        out_src,
    input  logic                    out_ready,
    output out_state_t              dbg_state,
    output logic [SRC_W-1:0]        dbg_ptr
);

    out_state_t        state_q, state_d;
    logic [SRC_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SRC_W-1:0]  src_q, src_d;

    logic [SRC_W-1:0]  win;
    logic              any;
    logic              can_load;
    logic              xfer;
    logic              lock_hit;
    logic [DATA_W-1:0] sel_data;

    rr_pick #(
        .N_REQ (N_REQ),
        .SRC_W (SRC_W)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .win (win),
        .any (any)
    );

    always_comb begin
        can_load = (state_q == OUT_EMPTY) || out_ready;
        xfer     = any && can_load && !rst;
        sel_data = req_data[win*DATA_W +: DATA_W];
`ifdef RR_MUX_ARB_LOCK_EN
        lock_hit = req_lock[win];
`else
        lock_hit = 1'b0;
`endif
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = xfer && (win == SRC_W'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        src_d   = src_q;
        if (xfer) begin
            state_d = OUT_FULL;
            data_d  = sel_data;
            src_d   = win;
            // A locked winner keeps top priority for its next word.
            ptr_d   = lock_hit ? win : win + SRC_W'(1);
        end else if (state_q == OUT_FULL && out_ready) begin
            state_d = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OUT_EMPTY;
            ptr_q   <= '0;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign out_valid = (state_q == OUT_FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;
    assign dbg_state = state_q;
    assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed testbench for rr_mux_arbiter (4 requesters, 4-bit data).
module tb_rr_mux_arbiter;
  import rr_mux_pkg::*;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 4;
  localparam int SRC_W  = 2;

  logic                    clk;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
`ifdef RR_MUX_ARB_LOCK_EN
  logic [N_REQ-1:0]        req_lock;
`endif
  logic [N_REQ-1:0]        req_ready;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic [SRC_W-1:0]        out_src;
  logic                    out_ready;
  out_state_t              dbg_state;
  logic [SRC_W-1:0]        dbg_ptr;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {src, data} words, oldest first.
  logic [SRC_W+DATA_W-1:0] exp_q[$];

  rr_mux_arbiter #(
    .N_REQ  (N_REQ),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef RR_MUX_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // One clock: inputs are driven and outputs sampled at the negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [N_REQ*DATA_W-1:0] pack(input logic [3:0] d0, input logic [3:0] d1,
                                                    input logic [3:0] d2, input logic [3:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    #1 check_eq("ready_in_reset", 32'(req_ready), 32'h0);
    step();
    rst = 1'b0;
  endtask

  // Pops the expected word and compares it with the output register.
  task automatic check_word(input string tag);
    logic [SRC_W+DATA_W-1:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_src_data"}, 32'({out_src, out_data}), 32'(e));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_data  = pack(4'd0, 4'd7, 4'd12, 4'd15);
    out_ready = 1'b1;
`ifdef RR_MUX_ARB_LOCK_EN
    req_lock  = '0;
`endif

    // Reset state.
    do_reset();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data",  32'(out_data),  32'd0);
    check_eq("rst_out_src",   32'(out_src),   32'd0);
    check_eq("rst_ptr",       32'(dbg_ptr),   32'd0);

    // All requesters valid: strict rotation 0,1,2,3,0.
    exp_q.push_back({2'd0, 4'd0});
    exp_q.push_back({2'd1, 4'd7});
    exp_q.push_back({2'd2, 4'd12});
    exp_q.push_back({2'd3, 4'd15});
    exp_q.push_back({2'd0, 4'd0});
    #1 check_eq("rr_ready_0", 32'(req_ready), 32'b0001);
    step(); check_word("rr0");
    check_eq("rr_ready_1", 32'(req_ready), 32'b0010);
    step(); check_word("rr1");
    check_eq("rr_ready_2", 32'(req_ready), 32'b0100);
    step(); check_word("rr2");
    check_eq("rr_ready_3", 32'(req_ready), 32'b1000);
    step(); check_word("rr3");
    check_eq("rr_ready_4", 32'(req_ready), 32'b0001);
    step(); check_word("rr4");
    check_eq("rr_ptr", 32'(dbg_ptr), 32'd1);

    // Single requester 2 streaming back to back.
    req_valid = 4'b0100;
    req_data  = pack(4'd1, 4'd1, 4'd9, 4'd1);
    for (int k = 0; k < 3; k++) begin
      #1 check_eq("solo_ready", 32'(req_ready), 32'b0100);
      step();
      check_eq("solo_valid", 32'(out_valid), 32'd1);
      check_eq("solo_src",   32'(out_src),   32'd2);
      check_eq("solo_data",  32'(out_data),  32'd9);
      check_eq("solo_ptr",   32'(dbg_ptr),   32'd3);
    end

    // Wrap from ptr=3: requester 3 then requester 0.
    req_valid = 4'b1001;
    req_data  = pack(4'd6, 4'd1, 4'd1, 4'd3);
    #1 check_eq("wrap_ready_3", 32'(req_ready), 32'b1000);
    step();
    check_eq("wrap_src_3", 32'(out_src), 32'd3);
    check_eq("wrap_data_3", 32'(out_data), 32'd3);
    check_eq("wrap_ptr_0", 32'(dbg_ptr), 32'd0);
    #1 check_eq("wrap_ready_0", 32'(req_ready), 32'b0001);
    step();
    check_eq("wrap_src_0", 32'(out_src), 32'd0);
    check_eq("wrap_data_0", 32'(out_data), 32'd6);
    check_eq("wrap_ptr_1", 32'(dbg_ptr), 32'd1);

    // Backpressure after the first word.
    req_valid = 4'b1111;
    req_data  = pack(4'd5, 4'd1, 4'd12, 4'd2);
    do_reset();
    step();
    check_eq("bp_first_src",  32'(out_src),  32'd0);
    check_eq("bp_first_data", 32'(out_data), 32'd5);
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1 check_eq("bp_ready", 32'(req_ready), 32'h0);
      step();
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_eq("bp_data",  32'(out_data),  32'd5);
      check_eq("bp_ptr",   32'(dbg_ptr),   32'd1);
    end
    out_ready = 1'b1;
    #1 check_eq("bp_release_ready", 32'(req_ready), 32'b0010);
    step();
    check_eq("bp_release_src",  32'(out_src),  32'd1);
    check_eq("bp_release_data", 32'(out_data), 32'd1);
    check_eq("bp_release_ptr",  32'(dbg_ptr),  32'd2);

    // Drain with no requests: word leaves, data/src hold, ptr unmoved.
    req_valid = 4'b0000;
    step();
    check_eq("drain_valid", 32'(out_valid), 32'd0);
    check_eq("drain_data",  32'(out_data),  32'd1);
    check_eq("drain_src",   32'(out_src),   32'd1);
    step();
    check_eq("idle_ptr", 32'(dbg_ptr), 32'd2);

    // Mid-stream reset while holding data 12.
    req_valid = 4'b1111;
    step();
    check_eq("mid_full_data", 32'(out_data), 32'd12);
    check_eq("mid_full_src",  32'(out_src),  32'd2);
    do_reset();
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_data",  32'(out_data),  32'd0);
    check_eq("mid_rst_src",   32'(out_src),   32'd0);
    check_eq("mid_rst_ptr",   32'(dbg_ptr),   32'd0);
    #1 check_eq("post_rst_ready", 32'(req_ready), 32'b0001);
    step();
    check_eq("post_rst_src",  32'(out_src),  32'd0);
    check_eq("post_rst_data", 32'(out_data), 32'd5);

`ifdef RR_MUX_ARB_LOCK_EN
    // Lock burst from requester 1, then release.
    do_reset();
    step();
    check_eq("lock_pre_src", 32'(out_src), 32'd0);
    req_lock = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("lock_src", 32'(out_src), 32'd1);
      check_eq("lock_ptr", 32'(dbg_ptr), 32'd1);
    end
    req_lock = 4'b0000;
    step();
    check_eq("unlock_src", 32'(out_src), 32'd1);
    step();
    check_eq("unlock_next_src", 32'(out_src), 32'd2);
`endif

    check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4:1 data selector among N_REQ requesters.
- Each requester offers DATA_W-bit words under a valid/ready handshake.
- The block picks a winner fairly, drives the selector, and registers the chosen word into a single-entry output stage with its own valid/ready handshake.
- Sits between the testbench/traffic sources and any downstream consumer of the muxed stream.

Parameters:
- N_REQ, 4, number of requesters (power of two, 2..8)
- DATA_W, 4, data width per requester
- SRC_W, $clog2(N_REQ), width of the source index

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- req_valid  input  N_REQ  per-requester word available
- req_data  input  N_REQ*DATA_W  packed words; requester i at [i*DATA_W +: DATA_W]
- req_ready  output  N_REQ  one-hot (or zero) acceptance, combinational
- out_valid  output  1  output register holds a word
- out_data  output  DATA_W  registered selected word
- out_src  output  SRC_W  index of the requester that supplied out_data
- out_ready  input  1  downstream accepts the word

Behaviour:
- Reset (rst=1 at posedge) clears all state:
  - ptr=0, out_valid=0, out_data=0, out_src=0.
  - req_ready=0 during the reset cycle regardless of inputs.
- Priority pointer ptr (SRC_W bits) names the highest-priority requester. The search order is ptr, ptr+1, ..., wrapping mod N_REQ.
- Combinational winner:
  - win = first i in search order with req_valid[i]=1.
  - any = |req_valid.
- Output register state machine, two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- can_load = (EMPTY) or (FULL and out_ready).
- req_ready[win] = any & can_load & ~rst. All other bits are 0.
- Transfer on requester i occurs when req_valid[i] & req_ready[i]. On that posedge:
  - out_data <= req_data[win], out_src <= win.
  - State becomes FULL.
  - ptr <= (win+1) mod N_REQ.
- FULL with out_ready=1 and no transfer -> EMPTY. out_data and out_src hold their last values.
- FULL with out_ready=1 and a transfer in the same cycle -> stays FULL with the new word. This gives back-to-back throughput of 1 word/cycle.
- FULL with out_ready=0 -> hold everything. req_ready is all zero, and ptr does not move.
- Latency: a word accepted at edge k is visible on out_data after edge k. That is one cycle from request to out_valid when EMPTY.
- Fairness: a continuously valid requester waits at most N_REQ-1 transfers.
- ptr wraps from N_REQ-1 to 0.
- ptr changes only on a transfer. Valid drops without a transfer do not move it.
- Requesters may deassert req_valid at any time before a transfer; no lock-in.
- req_data is sampled only at the transfer edge.
- Reset asserted mid-stream discards the held word: out_valid=0 after the edge and ptr=0.

Optional Feature:
- Macro: RR_MUX_ARB_LOCK_EN.
- When defined:
  - Adds input port req_lock (N_REQ bits).
  - If requester i transfers with req_lock[i]=1, ptr <= i instead of i+1. Requester i keeps top priority for the next transfer, which allows bursts.
  - A transfer with req_lock[i]=0 releases the hold and advances ptr normally.
  - If requester i drops valid while holding the lock, the search from ptr=i proceeds normally.
- When undefined: no req_lock port, pure round-robin as above.

Decomposition:
- Package rr_mux_pkg holds:
  - localparams N_REQ_DEF=4, DATA_W_DEF=4.
  - typedef src_t (logic [SRC_W-1:0]).
  - typedef enum {OUT_EMPTY, OUT_FULL} out_state_t.
- Sub-module rr_pick (combinational) is natural:
  - Inputs: req vector, ptr. Outputs: win index, any flag.
  - Implementation: rotate right by ptr, find first set bit, rotate index back.

Test Plan:
- Reset then all req_valid=4'b1111, out_ready=1, data in0..in3 = 0,7,12,15 -> out_src sequence 0,1,2,3,0... and out_data 0,7,12,15 on consecutive cycles; req_ready one-hot.
- Only req_valid[2]=1 with data 9, out_ready=1 for 3 cycles -> three transfers from src 2 with out_data=9 each cycle; ptr=3 after each.
- Backpressure: out_ready=0 after first word (src 0, data 5) with all valid -> out_valid stays 1, out_data=5 held, req_ready=0, ptr=1. Release out_ready -> next word from src 1.
- Wrap: ptr=3 (after src 2 transfer), req_valid=4'b1001 -> winner src 3, then src 0.
- Mid-stream rst=1 while FULL with out_data=12 -> next cycle out_valid=0, out_data=0, out_src=0; first post-reset grant goes to src 0 with all valid.
- With RR_MUX_ARB_LOCK_EN: src 1 valid with req_lock[1]=1 for 3 beats while all valid -> out_src = 1,1,1. Then req_lock[1]=0 on the 4th beat -> out_src = 1, then 2.
